// File: rtl/ex_unit_pkg.sv
// ex_unit_pkg: shared CPU defines used by decode and the execute stage.
// Holds the ALU opcode constants, the divider iteration count, the divider
// state enumeration and a small opcode-classification helper.
package ex_unit_pkg;

    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_SLLV = 8'h04;
    localparam logic [7:0] OP_SRLV = 8'h06;
    localparam logic [7:0] OP_SRAV = 8'h07;
    localparam logic [7:0] OP_ANDI = 8'h59;
    localparam logic [7:0] OP_XORI = 8'h5B;
    localparam logic [7:0] OP_LUI  = 8'h5C;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    // Last value of the 5-bit iteration counter (32 restoring steps).
    localparam logic [4:0] DIV_LAST_ITER = 5'd31;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_unit_if.sv
// ex_unit_if: decode <-> execute bundle.
//   decode drives : aluop_i, reg1_i, reg2_i, wreg_i, wd_i, flush_i
//   execute drives: fwd_wdata_o/fwd_wd_o/fwd_wreg_o (combinational forward),
//                   mem_wdata_o/mem_wd_o/mem_wreg_o (registered to memory stage),
//                   hi_o/lo_o/whilo_o (registered HI/LO write), stall_req_o
// modport master = decode side, modport slave = ex_unit side.
interface ex_unit_if;
    import ex_unit_pkg::*;

    logic [7:0]  aluop_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic        wreg_i;
    logic [4:0]  wd_i;
    logic        flush_i;

    logic [31:0] fwd_wdata_o;
    logic [4:0]  fwd_wd_o;
    logic        fwd_wreg_o;
    logic [31:0] mem_wdata_o;
    logic [4:0]  mem_wd_o;
    logic        mem_wreg_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        whilo_o;
    logic        stall_req_o;

    modport master (
        output aluop_i, reg1_i, reg2_i, wreg_i, wd_i, flush_i,
        input  fwd_wdata_o, fwd_wd_o, fwd_wreg_o,
        input  mem_wdata_o, mem_wd_o, mem_wreg_o,
        input  hi_o, lo_o, whilo_o, stall_req_o
    );

    modport slave (
        input  aluop_i, reg1_i, reg2_i, wreg_i, wd_i, flush_i,
        output fwd_wdata_o, fwd_wd_o, fwd_wreg_o,
        output mem_wdata_o, mem_wd_o, mem_wreg_o,
        output hi_o, lo_o, whilo_o, stall_req_o
    );

endinterface

// File: rtl/ex_unit_div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per BUSY cycle.
//   in : clk, rst (sync, active-high), start, signed_op, dividend, divisor, flush
//   out: busy (stall request), done (one cycle, result valid), quotient, remainder
//
// state    | meaning
// DIV_IDLE | waiting for start; magnitudes captured on the start cycle
// DIV_BUSY | one restoring step per cycle, counter 0..31
// DIV_DONE | sign-corrected result presented for one cycle
module div_iter
    import ex_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] quot_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic        neg_quot_q;
    logic        neg_rem_q;

    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [32:0] partial;
    logic [32:0] diff;
    logic        fit;

    assign dvd_mag = (signed_op && dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign dvs_mag = (signed_op && divisor[31])  ? (~divisor + 32'd1)  : divisor;

    // Remainder shifted left with the next dividend bit; rem_q < dvs_q keeps
    // this inside 33 bits.
    assign partial = {rem_q, quot_q[31]};
    assign fit     = (partial >= {1'b0, dvs_q});
    assign diff    = partial - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (start && !flush) begin
                    busy    = 1'b1;
                    // A zero divisor has a fixed answer, no iterations needed.
                    state_d = (divisor == 32'd0) ? DIV_DONE : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                busy = 1'b1;
                if (cnt_q == DIV_LAST_ITER) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
        if (flush) begin
            state_d = DIV_IDLE;
            busy    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (flush) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        cnt_q <= '0;
                        if (divisor == 32'd0) begin
                            // Raw dividend pattern goes straight to the remainder.
                            quot_q     <= 32'hFFFF_FFFF;
                            rem_q      <= dividend;
                            neg_quot_q <= 1'b0;
                            neg_rem_q  <= 1'b0;
                        end else begin
                            quot_q     <= dvd_mag;
                            rem_q      <= '0;
                            dvs_q      <= dvs_mag;
                            neg_quot_q <= signed_op && (dividend[31] ^ divisor[31]);
                            neg_rem_q  <= signed_op && dividend[31];
                        end
                    end
                end
                DIV_BUSY: begin
                    quot_q <= {quot_q[30:0], fit};
                    rem_q  <= fit ? diff[31:0] : partial[31:0];
                    cnt_q  <= cnt_q + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign done      = (state_q == DIV_DONE) && !flush;
    assign quotient  = neg_quot_q ? (~quot_q + 32'd1) : quot_q;
    assign remainder = neg_rem_q  ? (~rem_q + 32'd1)  : rem_q;

endmodule

// File: rtl/ex_unit.sv
// ex_unit: execute stage. Logic/shift/lui results are produced combinationally
// for forwarding and registered toward the memory stage; div/divu run on the
// iterative divider and write HI/LO once per division.
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : decode inputs, forward/memory/HI-LO outputs, stall request
module ex_unit
    import ex_unit_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    ex_unit_if.slave bus
);

    logic [31:0] alu_res;
    logic        op_writes;
    logic [4:0]  shamt;
    logic        div_start;
    logic        div_signed;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    assign shamt = bus.reg1_i[4:0];

    always_comb begin
        alu_res   = '0;
        op_writes = 1'b1;
        case (bus.aluop_i)
            OP_AND, OP_ANDI:  alu_res = bus.reg1_i & bus.reg2_i;
            OP_OR:            alu_res = bus.reg1_i | bus.reg2_i;
            OP_XOR, OP_XORI:  alu_res = bus.reg1_i ^ bus.reg2_i;
            OP_NOR:           alu_res = ~(bus.reg1_i | bus.reg2_i);
            OP_SLL, OP_SLLV:  alu_res = bus.reg2_i << shamt;
            OP_SRL, OP_SRLV:  alu_res = bus.reg2_i >> shamt;
            OP_SRA, OP_SRAV:  alu_res = $signed(bus.reg2_i) >>> shamt;
            OP_LUI:           alu_res = {bus.reg2_i[15:0], 16'h0000};
            // div/divu write HI/LO only; unknown opcodes write nothing.
            default:          op_writes = 1'b0;
        endcase
    end

    assign div_start  = is_div_op(bus.aluop_i);
    assign div_signed = (bus.aluop_i == OP_DIV);

    div_iter u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .signed_op (div_signed),
        .dividend  (bus.reg1_i),
        .divisor   (bus.reg2_i),
        .flush     (bus.flush_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    assign bus.fwd_wdata_o = alu_res;
    assign bus.fwd_wd_o    = bus.wd_i;
    assign bus.fwd_wreg_o  = bus.wreg_i && op_writes && !rst && !bus.flush_i;
    assign bus.stall_req_o = div_busy && !rst;

    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            bus.mem_wdata_o <= '0;
            bus.mem_wd_o    <= '0;
            bus.mem_wreg_o  <= 1'b0;
        end else begin
            bus.mem_wdata_o <= alu_res;
            bus.mem_wd_o    <= bus.wd_i;
            bus.mem_wreg_o  <= bus.fwd_wreg_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.hi_o    <= '0;
            bus.lo_o    <= '0;
            bus.whilo_o <= 1'b0;
        end else if (div_done) begin
            bus.hi_o    <= div_rem;
            bus.lo_o    <= div_quot;
            bus.whilo_o <= 1'b1;
        end else begin
            bus.whilo_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_unit.sv
module tb_ex_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_unit_if bus ();

    ex_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] op_tbl [15] = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03,
                                8'h04, 8'h06, 8'h07, 8'h59, 8'h5B, 8'h5C, 8'h00, 8'h55};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wr, input logic [4:0] wd, input logic fl);
        bus.aluop_i = op;
        bus.reg1_i  = a;
        bus.reg2_i  = b;
        bus.wreg_i  = wr;
        bus.wd_i    = wd;
        bus.flush_i = fl;
    endtask

    // Reference ALU: bitwise definition of each operation.
    function automatic void model_alu(input logic [7:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic wr,
                                      output logic [31:0] res, output logic wen);
        int sh;
        sh  = int'(a[4:0]);
        res = '0;
        wen = wr;
        case (op)
            8'h24, 8'h59: res = a & b;
            8'h25:        res = a | b;
            8'h26, 8'h5B: res = a ^ b;
            8'h27:        res = ~(a | b);
            8'h5C:        res = {b[15:0], 16'h0000};
            8'h7C, 8'h04: for (int i = 0; i < 32; i++) if (i >= sh) res[i] = b[i - sh];
            8'h02, 8'h06: for (int i = 0; i < 32; i++) if (i + sh < 32) res[i] = b[i + sh];
            8'h03, 8'h07: for (int i = 0; i < 32; i++) res[i] = (i + sh < 32) ? b[i + sh] : b[31];
            default:      wen = 1'b0;
        endcase
    endfunction

    // Reference divider: plain integer arithmetic with truncation toward zero.
    function automatic void model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic run_single(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic wr, input logic [4:0] wd);
        logic [31:0] exp_res;
        logic        exp_wen;
        model_alu(op, a, b, wr, exp_res, exp_wen);
        drive(op, a, b, wr, wd, 1'b0);
        #4;
        chk($sformatf("fwd_wdata op=%h", op), bus.fwd_wdata_o, exp_res);
        chk($sformatf("fwd_wreg op=%h", op), 32'(bus.fwd_wreg_o), 32'(exp_wen));
        chk("fwd_wd", 32'(bus.fwd_wd_o), 32'(wd));
        chk("stall_single", 32'(bus.stall_req_o), 32'd0);
        chk("whilo_single", 32'(bus.whilo_o), 32'd0);
        tick();
        chk($sformatf("mem_wdata op=%h", op), bus.mem_wdata_o, exp_res);
        chk("mem_wd", 32'(bus.mem_wd_o), 32'(wd));
        chk($sformatf("mem_wreg op=%h", op), 32'(bus.mem_wreg_o), 32'(exp_wen));
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_q, exp_r;
        int          stalls;
        int          exp_stalls;
        logic        early_whilo;
        model_div(sgn, a, b, exp_q, exp_r);
        exp_stalls  = (b == 32'd0) ? 1 : 33;
        stalls      = 0;
        early_whilo = 1'b0;
        drive(sgn ? 8'h1A : 8'h1B, a, b, 1'b1, 5'd7, 1'b0);
        #4;
        chk("div_fwd_wreg", 32'(bus.fwd_wreg_o), 32'd0);
        while (bus.stall_req_o && stalls < 100) begin
            stalls++;
            if (bus.whilo_o) early_whilo = 1'b1;
            tick();
            #4;
        end
        if (bus.whilo_o) early_whilo = 1'b1;
        chk($sformatf("div_stalls %h/%h", a, b), 32'(stalls), 32'(exp_stalls));
        chk("div_whilo_early", 32'(early_whilo), 32'd0);
        tick();
        drive(8'h00, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("div_whilo", 32'(bus.whilo_o), 32'd1);
        chk($sformatf("div_lo %h/%h", a, b), bus.lo_o, exp_q);
        chk($sformatf("div_hi %h/%h", a, b), bus.hi_o, exp_r);
        chk("div_mem_wreg", 32'(bus.mem_wreg_o), 32'd0);
        tick();
        chk("div_whilo_once", 32'(bus.whilo_o), 32'd0);
    endtask

    task automatic watch_no_whilo(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            drive(8'h00, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
            if (bus.whilo_o) seen = 1'b1;
            tick();
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;

        // Reset state, with a writing op and then a div presented under reset.
        rst = 1'b1;
        drive(8'h24, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd5, 1'b0);
        tick();
        tick();
        #4;
        chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
        chk("rst_mem_wd", 32'(bus.mem_wd_o), 32'd0);
        chk("rst_mem_wreg", 32'(bus.mem_wreg_o), 32'd0);
        chk("rst_hi", bus.hi_o, 32'd0);
        chk("rst_lo", bus.lo_o, 32'd0);
        chk("rst_whilo", 32'(bus.whilo_o), 32'd0);
        chk("rst_fwd_wreg", 32'(bus.fwd_wreg_o), 32'd0);
        tick();
        drive(8'h1A, 32'd9, 32'd2, 1'b1, 5'd1, 1'b0);
        #4;
        chk("rst_stall", 32'(bus.stall_req_o), 32'd0);
        tick();
        rst = 1'b0;
        drive(8'h00, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        tick();

        // Directed logic/shift/lui cases.
        run_single(8'h25, 32'h0000_FF00, 32'h00F0_000F, 1'b1, 5'd3);
        run_single(8'h03, 32'd4, 32'h8000_0000, 1'b1, 5'd8);
        run_single(8'h5C, 32'd0, 32'h0000_1234, 1'b1, 5'd9);
        run_single(8'h7C, 32'd31, 32'h0000_0001, 1'b1, 5'd2);
        run_single(8'h06, 32'd0, 32'hDEAD_BEEF, 1'b1, 5'd4);
        run_single(8'h55, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 5'd6);

        // Random single-cycle ops.
        for (int i = 0; i < 150; i++) begin
            run_single(op_tbl[$urandom_range(0, 14)], $urandom, $urandom,
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        // Directed divisions.
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div(1'b0, 32'd7, 32'd2);
        run_div(1'b0, 32'd5, 32'd0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd0);
        run_div(1'b1, 32'd100, 32'hFFFF_FFF9);

        // Random divisions.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (i % 4 == 1) rb = rb >> 20;
            run_div(1'($urandom_range(0, 1)), ra, rb);
        end

        // Flush at BUSY iteration 10, with a writing op presented alongside it.
        drive(8'h1B, 32'd1000, 32'd3, 1'b0, 5'd9, 1'b0);
        repeat (11) tick();
        drive(8'h25, 32'hF0F0_F0F0, 32'h0F0F_0000, 1'b1, 5'd9, 1'b1);
        #4;
        chk("flush_stall", 32'(bus.stall_req_o), 32'd0);
        chk("flush_fwd_wreg", 32'(bus.fwd_wreg_o), 32'd0);
        tick();
        drive(8'h00, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("flush_mem_wreg", 32'(bus.mem_wreg_o), 32'd0);
        chk("flush_mem_wdata", bus.mem_wdata_o, 32'd0);
        chk("flush_mem_wd", 32'(bus.mem_wd_o), 32'd0);
        chk("flush_whilo", 32'(bus.whilo_o), 32'd0);
        watch_no_whilo("flush_no_whilo", 40);
        run_single(8'h26, 32'hAAAA_5555, 32'h0F0F_0F0F, 1'b1, 5'd11);
        run_div(1'b0, 32'd1000, 32'd3);

        // Reset in the middle of a division.
        drive(8'h1A, 32'hFFFF_FF9C, 32'd7, 1'b0, 5'd12, 1'b0);
        repeat (15) tick();
        rst = 1'b1;
        tick();
        #4;
        chk("mrst_mem_wdata", bus.mem_wdata_o, 32'd0);
        chk("mrst_mem_wreg", 32'(bus.mem_wreg_o), 32'd0);
        chk("mrst_hi", bus.hi_o, 32'd0);
        chk("mrst_lo", bus.lo_o, 32'd0);
        chk("mrst_whilo", 32'(bus.whilo_o), 32'd0);
        chk("mrst_stall", 32'(bus.stall_req_o), 32'd0);
        chk("mrst_fwd_wreg", 32'(bus.fwd_wreg_o), 32'd0);
        tick();
        rst = 1'b0;
        watch_no_whilo("mrst_no_whilo", 40);
        run_single(8'h24, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 5'd13);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7);
        run_single(8'h26, 32'h1234_5678, 32'hFFFF_0000, 1'b1, 5'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
